// File: rtl/ddr3_pkg.sv
// Shared constants and state encoding for the DDR3 app-interface command sequencer.
package ddr3_pkg;
    localparam logic [2:0] APP_CMD_WRITE  = 3'b000;
    localparam logic [2:0] APP_CMD_READ   = 3'b001;
    localparam int         APP_ADDR_WIDTH = 29;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } seq_state_t;
endpackage

// File: rtl/ddr3_app_sequencer_if.sv
// MIG 7-series user (app) interface: command, write-data and read-return channels.
interface ddr3_app_sequencer_if import ddr3_pkg::*; #(
    parameter int DATA_WIDTH = 128
);
    logic [APP_ADDR_WIDTH-1:0] app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic                      app_rdy;
    logic [DATA_WIDTH-1:0]     app_wdf_data;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic [DATA_WIDTH/8-1:0]   app_wdf_mask;
    logic                      app_wdf_rdy;
    logic [DATA_WIDTH-1:0]     app_rd_data;
    logic                      app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr3_inflight_queue.sv
// Small synchronous FIFO of issued read addresses; push and pop may coincide.
module ddr3_inflight_queue #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // A pop frees the slot a same-cycle push lands in, so full+push+pop is legal.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ddr3_app_sequencer.sv
// Drains cache write/read-in FIFOs into MIG app commands and pairs read returns with addresses.
module ddr3_app_sequencer import ddr3_pkg::*; #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  calib_done,
    input  logic                  wr_fifo_empty,
    input  logic [ADDR_WIDTH-1:0] wr_fifo_addr,
    input  logic [DATA_WIDTH-1:0] wr_fifo_data,
    output logic                  wr_fifo_rd,
    input  logic                  rd_in_fifo_empty,
    input  logic [ADDR_WIDTH-1:0] rd_in_fifo_addr,
    output logic                  rd_in_fifo_rd,
    input  logic                  rd_out_fifo_full,
    output logic                  rd_out_fifo_wr,
    output logic [ADDR_WIDTH-1:0] rd_out_addr,
    output logic [DATA_WIDTH-1:0] rd_out_data,
    ddr3_app_sequencer_if.master  app,
    output logic                  busy,
    output logic                  err_orphan
);
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    seq_state_t                state, state_nxt;
    logic                      cmd_done, data_done;
    logic                      en_o, wren_o, load_wr, load_rd, ret_ok;
    logic [APP_ADDR_WIDTH-1:0] addr_q;
    logic [2:0]                cmd_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [ADDR_WIDTH-1:0]     req_addr, q_head;
    logic [CNT_W-1:0]          outstanding;

    // Byte address -> 16-bit-column address, burst-of-8 aligned (line bits 29:4).
    function automatic logic [APP_ADDR_WIDTH-1:0] to_app_addr(input logic [ADDR_WIDTH-1:0] a);
        return APP_ADDR_WIDTH'((a >> 4) << 3);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        en_o          = 1'b0;
        wren_o        = 1'b0;
        wr_fifo_rd    = 1'b0;
        rd_in_fifo_rd = 1'b0;
        load_wr       = 1'b0;
        load_rd       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && calib_done) begin
                    if (!wr_fifo_empty) begin
                        load_wr   = 1'b1;
                        state_nxt = ST_WRITE;
                    end else if (!rd_in_fifo_empty && (outstanding < MAX_CNT) && !rd_out_fifo_full) begin
                        load_rd   = 1'b1;
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                en_o   = !cmd_done;
                wren_o = !data_done;
                if ((cmd_done || app.app_rdy) && (data_done || app.app_wdf_rdy)) begin
                    wr_fifo_rd = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            ST_READ: begin
                en_o = 1'b1;
                if (app.app_rdy) begin
                    rd_in_fifo_rd = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command fields are captured on leaving IDLE so they hold steady until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_done  <= 1'b0;
            data_done <= 1'b0;
            addr_q    <= '0;
            cmd_q     <= APP_CMD_WRITE;
            wdata_q   <= '0;
            req_addr  <= '0;
        end else begin
            cmd_done  <= !wr_fifo_rd && (cmd_done  || (state == ST_WRITE && app.app_rdy));
            data_done <= !wr_fifo_rd && (data_done || (state == ST_WRITE && app.app_wdf_rdy));
            if (load_wr) begin
                addr_q  <= to_app_addr(wr_fifo_addr);
                cmd_q   <= APP_CMD_WRITE;
                wdata_q <= wr_fifo_data;
            end
            if (load_rd) begin
                addr_q   <= to_app_addr(rd_in_fifo_addr);
                cmd_q    <= APP_CMD_READ;
                req_addr <= rd_in_fifo_addr;
            end
        end
    end

    assign app.app_en       = en_o;
    assign app.app_cmd      = cmd_q;
    assign app.app_addr     = addr_q;
    assign app.app_wdf_data = wdata_q;
    assign app.app_wdf_wren = wren_o;
    assign app.app_wdf_end  = wren_o;
    assign app.app_wdf_mask = '0;

    assign ret_ok = app.app_rd_data_valid && (outstanding != '0);

    ddr3_inflight_queue #(.DEPTH(MAX_OUTSTANDING), .WIDTH(ADDR_WIDTH)) u_inflight (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_in_fifo_rd),
        .push_data (req_addr),
        .pop       (ret_ok),
        .head      (q_head),
        .count     (outstanding)
    );

    // Return path never stalls; issue-side checks keep the read-out FIFO from overflowing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_out_fifo_wr <= 1'b0;
            rd_out_addr    <= '0;
            rd_out_data    <= '0;
            err_orphan     <= 1'b0;
        end else begin
            rd_out_fifo_wr <= ret_ok;
            if (ret_ok) begin
                rd_out_data <= app.app_rd_data;
                rd_out_addr <= q_head & ~ADDR_WIDTH'(4'hF);
            end
            if (app.app_rd_data_valid && outstanding == '0) err_orphan <= 1'b1;
        end
    end

    assign busy = (state != ST_IDLE) || (outstanding != '0);
endmodule
